// File: rtl/module_program_loader_if.sv
// Boot-loader bus: byte stream in (valid/ready), instruction-memory write port out,
// plus core release (cpu_run) and sticky error.
// Ports: in_data/in_valid/in_ready (stream), mem_wr_en/mem_addr/mem_data (imem write),
//        cpu_run, err. master = stream source / observer side, slave = loader side.
interface module_program_loader_if #(
  parameter int WORD_SIZE  = 32,
  parameter int ADDR_WIDTH = 32
);
  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  mem_wr_en;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [WORD_SIZE-1:0]  mem_data;
  logic                  cpu_run;
  logic                  err;

  modport master (
    output in_data, in_valid,
    input  in_ready, mem_wr_en, mem_addr, mem_data, cpu_run, err
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, mem_wr_en, mem_addr, mem_data, cpu_run, err
  );
endinterface

// File: rtl/module_program_loader.sv
// Purpose: boot loader; parses a 16-bit big-endian word count, packs big-endian words
//          from a byte stream, writes them to instruction memory, then releases the core.
// Latency: mem_wr_en pulses one cycle after the edge accepting a word's final byte.
// Backpressure: in_ready low in reset, for one cycle after the final data byte, and in DONE.
// Ports: clk, rst (async, active-low), bus (module_program_loader_if.slave).
// Option: define LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module module_program_loader #(
  parameter int WORD_SIZE  = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_WORDS  = 1024,
  parameter int ADDR_STEP  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  module_program_loader_if.slave   bus
);

  localparam int BYTES = WORD_SIZE / 8;
  localparam int BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [BCW-1:0]        LAST_B = BCW'(BYTES - 1);
  localparam logic [16:0]           MAXW   = 17'(MAX_WORDS);
  localparam logic [ADDR_WIDTH-1:0] STEP   = ADDR_WIDTH'(ADDR_STEP);

  // S_FIN is a one-cycle gap after the image body: it lets the final write
  // pulse and the core release land on the same edge without accepting a
  // stray byte in between.
  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_FIN,
`ifdef LOADER_CHECKSUM_EN
    S_CHK,
`endif
    S_DONE,
    S_ERR
  } state_t;

  state_t                state_q;
  logic [7:0]            hdr_hi_q;
  logic [15:0]           remain_q;
  logic [BCW-1:0]        bcnt_q;
  logic [WORD_SIZE-1:0]  word_q;
  logic                  wr_pend_q;
  logic [ADDR_WIDTH-1:0] waddr_q;
  logic                  in_ready_q;
  logic                  mem_wr_en_q;
  logic [ADDR_WIDTH-1:0] mem_addr_q;
  logic [WORD_SIZE-1:0]  mem_data_q;
  logic                  cpu_run_q;
  logic                  err_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            xor_q;
`endif

  logic                  accept;
  logic [15:0]           count_d;
  logic [WORD_SIZE-1:0]  word_d;

  always_comb begin
    accept  = bus.in_valid && in_ready_q;
    count_d = {hdr_hi_q, bus.in_data};
    // Shift-in MSB-first: first byte of a word ends up in the top byte.
    word_d  = (word_q << 8) | WORD_SIZE'(bus.in_data);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_LEN_HI;
      hdr_hi_q    <= '0;
      remain_q    <= '0;
      bcnt_q      <= '0;
      word_q      <= '0;
      wr_pend_q   <= 1'b0;
      waddr_q     <= '0;
      in_ready_q  <= 1'b0;
      mem_wr_en_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      cpu_run_q   <= 1'b0;
      err_q       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      xor_q       <= '0;
`endif
    end else begin
      mem_wr_en_q <= 1'b0;

      // word_q already holds the complete word here; a byte accepted on this
      // same edge for the next word shifts in without disturbing the capture.
      if (wr_pend_q) begin
        mem_wr_en_q <= 1'b1;
        mem_addr_q  <= waddr_q;
        mem_data_q  <= word_q;
        waddr_q     <= waddr_q + STEP;
        wr_pend_q   <= 1'b0;
      end

      case (state_q)
        S_LEN_HI: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            hdr_hi_q <= bus.in_data;
            state_q  <= S_LEN_LO;
          end
        end

        S_LEN_LO: begin
          if (accept) begin
            remain_q <= count_d;
            if (count_d == 16'd0) begin
              state_q    <= S_FIN;
              in_ready_q <= 1'b0;
            end else if ({1'b0, count_d} > MAXW) begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
            end else begin
              state_q <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (accept) begin
            word_q <= word_d;
`ifdef LOADER_CHECKSUM_EN
            xor_q  <= xor_q ^ bus.in_data;
`endif
            if (bcnt_q == LAST_B) begin
              bcnt_q    <= '0;
              wr_pend_q <= 1'b1;
              remain_q  <= remain_q - 16'd1;
              if (remain_q == 16'd1) begin
                state_q    <= S_FIN;
                in_ready_q <= 1'b0;
              end
            end else begin
              bcnt_q <= bcnt_q + BCW'(1);
            end
          end
        end

        S_FIN: begin
`ifdef LOADER_CHECKSUM_EN
          state_q    <= S_CHK;
          in_ready_q <= 1'b1;
`else
          state_q    <= S_DONE;
          cpu_run_q  <= 1'b1;
`endif
        end

`ifdef LOADER_CHECKSUM_EN
        S_CHK: begin
          if (accept) begin
            if (bus.in_data == xor_q) begin
              state_q    <= S_DONE;
              cpu_run_q  <= 1'b1;
              in_ready_q <= 1'b0;
            end else begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
            end
          end
        end
`endif

        S_DONE: begin
          in_ready_q <= 1'b0;
          cpu_run_q  <= 1'b1;
        end

        S_ERR: begin
          in_ready_q <= 1'b1;
          err_q      <= 1'b1;
          cpu_run_q  <= 1'b0;
        end

        default: begin
          state_q <= S_ERR;
          err_q   <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.mem_wr_en = mem_wr_en_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_data  = mem_data_q;
  assign bus.cpu_run   = cpu_run_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_module_program_loader.sv
// Directed bench for module_program_loader: header parsing, word packing, write
// timing, DONE/ERR behaviour, stalls, mid-load reset and (optionally) checksum.
module tb_module_program_loader;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  module_program_loader_if #(.WORD_SIZE(32), .ADDR_WIDTH(32)) bus ();

  module_program_loader #(
    .WORD_SIZE(32), .ADDR_WIDTH(32), .MAX_WORDS(1024), .ADDR_STEP(1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int run_cyc = -1;
  int last_acc = 0;
  int n_acc = 0;
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Log every write pulse and the first cycle cpu_run is seen high.
  always @(negedge clk) begin
    if (rst && bus.mem_wr_en) begin
      wr_addr.push_back(bus.mem_addr);
      wr_data.push_back(bus.mem_data);
      wr_cyc.push_back(cyc);
    end
    if (rst && bus.cpu_run && run_cyc < 0) run_cyc = cyc;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    run_cyc = -1;
  endtask

  task automatic send(input logic [7:0] b);
    logic rdy;
    logic ok;
    ok = 1'b0;
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      rdy = bus.in_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    last_acc = cyc;
    if (ok) n_acc++;
    else check("accept_timeout", 64'(ok), 64'd1);
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    bus.in_valid = 1'b0;
    rst = 1'b0;
    #1;
    clear_log();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_in_ready"},  64'(bus.in_ready),  64'd0);
    check({pfx, "_mem_wr_en"}, 64'(bus.mem_wr_en), 64'd0);
    check({pfx, "_mem_addr"},  64'(bus.mem_addr),  64'd0);
    check({pfx, "_mem_data"},  64'(bus.mem_data),  64'd0);
    check({pfx, "_cpu_run"},   64'(bus.cpu_run),   64'd0);
    check({pfx, "_err"},       64'(bus.err),       64'd0);
  endtask

  initial begin
    int acc0;
    bus.in_data  = 8'h00;
    bus.in_valid = 1'b0;

    // Reset values while reset is held.
    #12;
    check_reset_outputs("rst");
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Two-word image, valid held high.
    send(8'h00); send(8'h02);
    send(8'h12); send(8'h34); send(8'h56); send(8'h78);
    send(8'h9A); send(8'hBC); send(8'hDE); send(8'hF0);
    idle(3);
    check("two_wr_count", 64'(wr_cyc.size()), 64'd2);
    check("two_addr0", 64'(wr_addr[0]), 64'h0);
    check("two_data0", 64'(wr_data[0]), 64'h12345678);
    check("two_addr1", 64'(wr_addr[1]), 64'h1);
    check("two_data1", 64'(wr_data[1]), 64'h9ABCDEF0);
    check("two_spacing", 64'(wr_cyc[1] - wr_cyc[0]), 64'd4);
    check("two_latency", 64'(wr_cyc[1]), 64'(last_acc + 1));
    check("two_run_cyc", 64'(run_cyc), 64'(wr_cyc[1]));
    check("two_cpu_run", 64'(bus.cpu_run), 64'd1);
    check("two_in_ready", 64'(bus.in_ready), 64'd0);
    check("two_hold_addr", 64'(bus.mem_addr), 64'h1);
    check("two_hold_data", 64'(bus.mem_data), 64'h9ABCDEF0);
    check("two_wr_en_low", 64'(bus.mem_wr_en), 64'd0);
    // DONE ignores further traffic.
    bus.in_data  = 8'hAA;
    bus.in_valid = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    bus.in_valid = 1'b0;
    check("done_ignore_wr", 64'(wr_cyc.size()), 64'd2);
    check("done_cpu_run", 64'(bus.cpu_run), 64'd1);

    // Zero-count image.
    do_reset();
    send(8'h00); send(8'h00);
`ifdef LOADER_CHECKSUM_EN
    send(8'h00);
    idle(3);
    check("zero_run_cyc", 64'(run_cyc), 64'(last_acc));
`else
    idle(3);
    check("zero_run_cyc", 64'(run_cyc), 64'(last_acc + 1));
`endif
    check("zero_no_wr", 64'(wr_cyc.size()), 64'd0);
    check("zero_cpu_run", 64'(bus.cpu_run), 64'd1);
    check("zero_err", 64'(bus.err), 64'd0);

    // Oversize count 0x0401 = 1025 words.
    do_reset();
    send(8'h04); send(8'h01);
    idle(1);
    check("over_err", 64'(bus.err), 64'd1);
    check("over_cpu_run", 64'(bus.cpu_run), 64'd0);
    check("over_in_ready", 64'(bus.in_ready), 64'd1);
    acc0 = n_acc;
    for (int i = 0; i < 100; i++) send(8'(i));
    idle(2);
    check("over_accepted", 64'(n_acc - acc0), 64'd100);
    check("over_no_wr", 64'(wr_cyc.size()), 64'd0);
    check("over_err_sticky", 64'(bus.err), 64'd1);

    // 3-word load with random stalls, reset after 6 data bytes.
    do_reset();
    send(8'h00); send(8'h03);
    for (int k = 0; k < 6; k++) begin
      idle($urandom_range(0, 2));
      send(8'(8'h11 * (k + 1)));
    end
    idle(2);
    check("stall_wr_count", 64'(wr_cyc.size()), 64'd1);
    check("stall_addr0", 64'(wr_addr[0]), 64'h0);
    check("stall_data0", 64'(wr_data[0]), 64'h11223344);
    check("stall_cpu_run", 64'(bus.cpu_run), 64'd0);
    rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    clear_log();
    @(posedge clk);
    #1;
    rst = 1'b1;
    send(8'h00); send(8'h01);
    send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
`ifdef LOADER_CHECKSUM_EN
    send(8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF);
`endif
    idle(3);
    check("fresh_wr_count", 64'(wr_cyc.size()), 64'd1);
    check("fresh_addr0", 64'(wr_addr[0]), 64'h0);
    check("fresh_data0", 64'(wr_data[0]), 64'hDEADBEEF);
    check("fresh_cpu_run", 64'(bus.cpu_run), 64'd1);

    // Checksum image: data XOR = 01^02^04^08 = 0F.
    do_reset();
    send(8'h00); send(8'h01);
    send(8'h01); send(8'h02); send(8'h04); send(8'h08);
`ifdef LOADER_CHECKSUM_EN
    send(8'h0F);
`endif
    idle(3);
    check("csum_ok_data", 64'(wr_data[0]), 64'h01020408);
    check("csum_ok_run", 64'(bus.cpu_run), 64'd1);
    check("csum_ok_err", 64'(bus.err), 64'd0);
`ifdef LOADER_CHECKSUM_EN
    do_reset();
    send(8'h00); send(8'h01);
    send(8'h01); send(8'h02); send(8'h04); send(8'h08);
    send(8'h0E);
    idle(3);
    check("csum_bad_err", 64'(bus.err), 64'd1);
    check("csum_bad_run", 64'(bus.cpu_run), 64'd0);
    check("csum_bad_ready", 64'(bus.in_ready), 64'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/module_program_loader.md
# module_program_loader

Boot-time loader that sits directly upstream of the instruction memory and the cpu core. It accepts a byte stream over a valid/ready handshake, parses a 16-bit word-count header, assembles big-endian 32-bit instruction words and writes them into instruction memory at consecutive addresses. It holds the core in reset until the image is complete, then releases it through `cpu_run`.

## Interface
- `WORD_SIZE`, 32, instruction word width; must be a multiple of 8.
- `ADDR_WIDTH`, 32, instruction-memory address width.
- `MAX_WORDS`, 1024, largest accepted image size in words.
- `ADDR_STEP`, 1, address increment per written word.

Ports:
- `clk`  input  1  system clock; all state changes on its rising edge.
- `rst`  input  1  reset; asynchronous, active-low (0 = reset).
- `in_data`  input  8  stream byte.
- `in_valid`  input  1  `in_data` is valid.
- `in_ready`  output  1  loader can accept a byte.
- `mem_wr_en`  output  1  one-cycle instruction-memory write strobe.
- `mem_addr`  output  ADDR_WIDTH  write address.
- `mem_data`  output  WORD_SIZE  write data.
- `cpu_run`  output  1  1 = image loaded and core released; drives the core's active-low reset.
- `err`  output  1  sticky load error.

## Operation
- **Accept rule.** A byte is accepted on any rising edge with `in_valid && in_ready`. No other input has effect.
- **LEN_HI.** Accepted byte becomes count[15:8]. Go to LEN_LO.
- **LEN_LO.** Accepted byte becomes count[7:0], then:
  - count == 0: go to DONE (or CHK when checksum is enabled).
  - count > MAX_WORDS: go to ERR.
  - otherwise: go to DATA.
- **DATA.**
  - Bytes shift into the word register MSB-first; the first byte lands in bits [31:24].
  - A 2-bit byte counter wraps after WORD_SIZE/8 bytes.
  - On the last byte of a word, the next cycle presents `mem_wr_en`=1 with `mem_addr` = current write address and `mem_data` = the assembled word.
  - The write address then advances by ADDR_STEP, and the remaining-word counter decrements.
  - When the remaining count reaches 0, go to DONE (or CHK).
- **DONE.** `cpu_run`=1 and `in_ready`=0. Bytes are ignored. Stays in DONE until reset.
- **ERR.** `err`=1, `cpu_run`=0, `in_ready`=1. All bytes are accepted and discarded. Stays in ERR until reset.
- **Address arithmetic.** The write address starts at 0 and is modulo 2^ADDR_WIDTH; it wraps silently.
- **Counter width.** The remaining-word counter is 16 bits.
- **`in_ready`.** 1 in LEN_HI, LEN_LO, DATA, CHK and ERR; 0 in DONE and while in reset.

## Timing
- **Reset values** (asserted asynchronously):
  - state = LEN_HI
  - `in_ready`=0 during reset, rising to 1 on the first clock after release
  - `mem_wr_en`=0, `mem_addr`=0, `mem_data`=0
  - `cpu_run`=0, `err`=0
  - write address = 0, byte counter = 0
- **Write latency.** `mem_wr_en` rises exactly one cycle after the edge that accepts a word's final byte. It is always a single-cycle pulse. `mem_addr` and `mem_data` hold their values until the next write.
- **Throughput.** One byte per cycle, sustained. Back-to-back words produce `mem_wr_en` pulses 4 cycles apart.
- **Stalls.** `in_valid` may drop at any point. The byte and word counters hold state while `in_valid`=0.
- **`cpu_run` timing.** `cpu_run` is registered. It rises on the edge that enters DONE, which is the same edge on which the last `mem_wr_en` is asserted. The memory write and the core's release therefore coincide; instruction memory must accept a write in that cycle.
- **Reset mid-load.** Aborts immediately. All outputs return to reset values. Instruction-memory contents are left as written.

## Configuration
- **`LOADER_CHECKSUM_EN` defined:**
  - After the final data word (or after a zero count), state CHK accepts one byte.
  - That byte is compared against the running XOR of all data bytes (initial value 0x00).
  - Match: go to DONE. Mismatch: go to ERR.
  - Header bytes are excluded from the XOR.
- **`LOADER_CHECKSUM_EN` undefined:**
  - No CHK state; DONE follows the last data word directly.
  - No running-XOR register is built.

## Test plan
- **Two-word image.** Stream 00 02 12 34 56 78 9A BC DE F0 with `in_valid` held high.
  - Write of 0x12345678 at address 0, then 0x9ABCDEF0 at address 1, 4 cycles apart.
  - `cpu_run`=1 from the cycle of the second write.
- **Zero count.** Stream 00 00.
  - No `mem_wr_en`; `cpu_run`=1 one cycle after the second byte is accepted.
  - With the macro enabled, the bench sends 00 as the checksum byte first.
- **Oversize count.** Stream 04 01 with MAX_WORDS=1024.
  - `err`=1 and `cpu_run`=0.
  - 100 further bytes are accepted with no writes.
- **Stalls and reset.** Randomly toggle `in_valid` during a 3-word load, then assert `rst`=0 after 6 data bytes.
  - Outputs return to reset values immediately.
  - A fresh 1-word load then writes at address 0.
- **Checksum (`LOADER_CHECKSUM_EN`).**
  - 00 01 01 02 04 08 0F: `cpu_run`=1.
  - Same stream with final byte 0E: `err`=1, `cpu_run`=0.
